wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: three single-entry holding buffers (ALU, LSU, MDU)
// share one write port round-robin; the granted entry is registered onto the port.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int RFIDX = 5
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_alu_vld,
  input  logic [RFIDX-1:0] i_alu_rdidx,
  input  logic [XLEN-1:0]  i_alu_wdata,
  output logic             o_alu_rdy,
  input  logic             i_lsu_vld,
  input  logic [RFIDX-1:0] i_lsu_rdidx,
  input  logic [XLEN-1:0]  i_lsu_wdata,
  output logic             o_lsu_rdy,
  input  logic             i_mdu_vld,
  input  logic [RFIDX-1:0] i_mdu_rdidx,
  input  logic [XLEN-1:0]  i_mdu_wdata,
  output logic             o_mdu_rdy,
  output logic             o_rdwen,
  output logic [RFIDX-1:0] o_rdidx,
  output logic [XLEN-1:0]  o_rd_wdata,
  output logic [2:0]       o_wb_pend
);

  logic [2:0]       r_full;
  logic [RFIDX-1:0] r_idx [3];
  logic [XLEN-1:0]  r_dat [3];
  logic [1:0]       r_last;
  logic             r_rdwen;
  logic [RFIDX-1:0] r_rdidx;
  logic [XLEN-1:0]  r_rd_wdata;

  logic [2:0]       w_vld;
  logic [RFIDX-1:0] w_in_idx [3];
  logic [XLEN-1:0]  w_in_dat [3];
  logic [2:0]       w_gnt;
  logic [1:0]       w_gidx;
  logic [2:0]       w_rdy;
  logic [2:0]       w_acc;

  assign w_vld       = {i_mdu_vld, i_lsu_vld, i_alu_vld};
  assign w_in_idx[0] = i_alu_rdidx;
  assign w_in_idx[1] = i_lsu_rdidx;
  assign w_in_idx[2] = i_mdu_rdidx;
  assign w_in_dat[0] = i_alu_wdata;
  assign w_in_dat[1] = i_lsu_wdata;
  assign w_in_dat[2] = i_mdu_wdata;

  // Search order starts one past the last granted requester.
  always_comb begin
    w_gnt  = 3'b000;
    w_gidx = 2'd0;
    case (r_last)
      2'd0: begin
        if      (r_full[1]) begin w_gnt = 3'b010; w_gidx = 2'd1; end
        else if (r_full[2]) begin w_gnt = 3'b100; w_gidx = 2'd2; end
        else if (r_full[0]) begin w_gnt = 3'b001; w_gidx = 2'd0; end
      end
      2'd1: begin
        if      (r_full[2]) begin w_gnt = 3'b100; w_gidx = 2'd2; end
        else if (r_full[0]) begin w_gnt = 3'b001; w_gidx = 2'd0; end
        else if (r_full[1]) begin w_gnt = 3'b010; w_gidx = 2'd1; end
      end
      default: begin
        if      (r_full[0]) begin w_gnt = 3'b001; w_gidx = 2'd0; end
        else if (r_full[1]) begin w_gnt = 3'b010; w_gidx = 2'd1; end
        else if (r_full[2]) begin w_gnt = 3'b100; w_gidx = 2'd2; end
      end
    endcase
  end

  // A buffer draining this cycle can take a new entry in the same cycle.
  assign w_rdy = ~r_full | w_gnt;
  assign w_acc = w_vld & w_rdy;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_full <= 3'b000;
      r_last <= 2'd2;
      for (int i = 0; i < 3; i++) begin
        r_idx[i] <= '0;
        r_dat[i] <= '0;
      end
    end else begin
      if (|w_gnt) r_last <= w_gidx;
      for (int i = 0; i < 3; i++) begin
        if (w_acc[i]) begin
          r_full[i] <= 1'b1;
          r_idx[i]  <= w_in_idx[i];
          r_dat[i]  <= w_in_dat[i];
        end else if (w_gnt[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // x0 writes still use their slot but never enable the write port.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rdwen    <= 1'b0;
      r_rdidx    <= '0;
      r_rd_wdata <= '0;
    end else if (|w_gnt) begin
      r_rdwen    <= (r_idx[w_gidx] != '0);
      r_rdidx    <= r_idx[w_gidx];
      r_rd_wdata <= r_dat[w_gidx];
    end else begin
      r_rdwen    <= 1'b0;
    end
  end

  assign o_alu_rdy  = w_rdy[0];
  assign o_lsu_rdy  = w_rdy[1];
  assign o_mdu_rdy  = w_rdy[2];
  assign o_rdwen    = r_rdwen;
  assign o_rdidx    = r_rdidx;
  assign o_rd_wdata = r_rd_wdata;
  assign o_wb_pend  = r_full;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run against a
// round-robin reference model and a per-requester scoreboard.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  vld = 3'b000;
  logic [4:0]  ridx [3];
  logic [31:0] wdat [3];
  logic        alu_rdy, lsu_rdy, mdu_rdy;
  logic        rdwen;
  logic [4:0]  rdidx;
  logic [31:0] rd_wdata;
  logic [2:0]  pend;
  logic [2:0]  rdy;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_full [3];
  logic [4:0]  m_idx [3];
  logic [31:0] m_dat [3];
  bit          m_acc [3];
  int          m_last;
  bit          e_wen;
  logic [4:0]  e_idx;
  logic [31:0] e_dat;
  logic [36:0] sbq [3][$];
  int          stall [3];
  int          seq [3];

  wb_arbiter #(.XLEN(32), .RFIDX(5)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_alu_vld(vld[0]), .i_alu_rdidx(ridx[0]), .i_alu_wdata(wdat[0]), .o_alu_rdy(alu_rdy),
    .i_lsu_vld(vld[1]), .i_lsu_rdidx(ridx[1]), .i_lsu_wdata(wdat[1]), .o_lsu_rdy(lsu_rdy),
    .i_mdu_vld(vld[2]), .i_mdu_rdidx(ridx[2]), .i_mdu_wdata(wdat[2]), .o_mdu_rdy(mdu_rdy),
    .o_rdwen(rdwen), .o_rdidx(rdidx), .o_rd_wdata(rd_wdata), .o_wb_pend(pend)
  );

  assign rdy = {mdu_rdy, lsu_rdy, alu_rdy};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    vld = 3'b000;
    for (int s = 0; s < 3; s++) begin
      ridx[s] = 5'd0;
      wdat[s] = 32'd0;
    end
  endtask

  task automatic do_reset();
    clear_req();
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    clear_req();
    rstn = 1'b0;
    #2;
    checks++;
    if (rdwen !== 1'b0 || rdidx !== 5'd0 || rd_wdata !== 32'd0 || pend !== 3'b000)
      begin errors++; $display("FAIL reset_outputs: wen=%b idx=%0d data=%h pend=%b, want 0/0/0/000", rdwen, rdidx, rd_wdata, pend); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (rdy !== 3'b111) begin errors++; $display("FAIL reset_rdy: rdy=%b want 111", rdy); end
    $display("reset: pend=%b rdy=%b", pend, rdy);
  endtask

  task automatic test_single_alu();
    tick();
    vld[0] = 1'b1; ridx[0] = 5'd5; wdat[0] = 32'h12345678;
    tick();
    vld[0] = 1'b0;
    checks++;
    if (pend !== 3'b001 || rdwen !== 1'b0)
      begin errors++; $display("FAIL single_accept: pend=%b wen=%b, want 001/0", pend, rdwen); end
    tick();
    checks++;
    if (rdwen !== 1'b1 || rdidx !== 5'd5 || rd_wdata !== 32'h12345678)
      begin errors++; $display("FAIL single_write: wen=%b idx=%0d data=%h, want 1/5/12345678", rdwen, rdidx, rd_wdata); end
    $display("single_alu: wen=%b idx=%0d data=%h", rdwen, rdidx, rd_wdata);
    tick();
    checks++;
    if (rdwen !== 1'b0 || rdidx !== 5'd5 || pend !== 3'b000)
      begin errors++; $display("FAIL single_after: wen=%b idx=%0d pend=%b, want 0/5/000", rdwen, rdidx, pend); end
  endtask

  task automatic test_all_three();
    logic [2:0] exp_pend [4];
    do_reset();
    exp_pend[0] = 3'b111; exp_pend[1] = 3'b110; exp_pend[2] = 3'b100; exp_pend[3] = 3'b000;
    tick();
    for (int s = 0; s < 3; s++) begin
      vld[s] = 1'b1; ridx[s] = 5'(s + 1); wdat[s] = 32'hA0 + 32'(s);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      clear_req();
      if (c < 4) begin
        checks++;
        if (pend !== exp_pend[c]) begin errors++; $display("FAIL all3_pend[%0d]: pend=%b want %b", c, pend, exp_pend[c]); end
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if (rdwen !== 1'b1 || rdidx !== 5'(c) || rd_wdata !== 32'hA0 + 32'(c - 1))
          begin errors++; $display("FAIL all3_write[%0d]: wen=%b idx=%0d data=%h, want 1/%0d/%h", c, rdwen, rdidx, rd_wdata, c, 32'hA0 + 32'(c - 1)); end
        $display("all3: wen=%b idx=%0d data=%h pend=%b", rdwen, rdidx, rd_wdata, pend);
      end else begin
        checks++;
        if (rdwen !== 1'b0) begin errors++; $display("FAIL all3_idle[%0d]: wen=%b want 0", c, rdwen); end
      end
    end
  endtask

  task automatic test_stream();
    int ak, lk;
    bit ea, el;
    do_reset();
    ak = 0; lk = 0;
    tick();
    for (int c = 0; c < 10; c++) begin
      vld[0] = 1'b1; ridx[0] = 5'd7; wdat[0] = 32'hA000_0000 + 32'(ak);
      vld[1] = 1'b1; ridx[1] = 5'd9; wdat[1] = 32'hB000_0000 + 32'(lk);
      ea = (c == 0) || (c % 2 == 1);
      el = (c == 0) || (c % 2 == 0);
      checks++;
      if (alu_rdy !== ea || lsu_rdy !== el)
        begin errors++; $display("FAIL stream_rdy[%0d]: alu=%b lsu=%b, want %b %b", c, alu_rdy, lsu_rdy, ea, el); end
      tick();
      if (ea) ak++;
      if (el) lk++;
      checks++;
      if (c == 0) begin
        if (rdwen !== 1'b0) begin errors++; $display("FAIL stream_first: wen=%b want 0", rdwen); end
      end else if (c % 2 == 1) begin
        if (rdwen !== 1'b1 || rdidx !== 5'd7 || rd_wdata !== 32'hA000_0000 + 32'((c - 1) / 2))
          begin errors++; $display("FAIL stream_alu[%0d]: wen=%b idx=%0d data=%h", c, rdwen, rdidx, rd_wdata); end
      end else begin
        if (rdwen !== 1'b1 || rdidx !== 5'd9 || rd_wdata !== 32'hB000_0000 + 32'(c / 2 - 1))
          begin errors++; $display("FAIL stream_lsu[%0d]: wen=%b idx=%0d data=%h", c, rdwen, rdidx, rd_wdata); end
      end
      $display("stream[%0d]: wen=%b idx=%0d data=%h", c, rdwen, rdidx, rd_wdata);
    end
    clear_req();
  endtask

  task automatic test_x0();
    do_reset();
    tick();
    vld[2] = 1'b1; ridx[2] = 5'd0; wdat[2] = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (mdu_rdy !== 1'b1) begin errors++; $display("FAIL x0_rdy: mdu_rdy=%b want 1", mdu_rdy); end
    tick();
    clear_req();
    checks++;
    if (pend !== 3'b100 || rdwen !== 1'b0) begin errors++; $display("FAIL x0_pend: pend=%b wen=%b want 100/0", pend, rdwen); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (pend !== 3'b000 || rdwen !== 1'b0) begin errors++; $display("FAIL x0_drain[%0d]: pend=%b wen=%b want 000/0", c, pend, rdwen); end
    end
    $display("x0: mdu write idx=0 produced wen=%b", rdwen);
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    vld[1] = 1'b1; ridx[1] = 5'd10; wdat[1] = 32'h1111;
    vld[2] = 1'b1; ridx[2] = 5'd11; wdat[2] = 32'h2222;
    tick();
    clear_req();
    checks++;
    if (pend !== 3'b110) begin errors++; $display("FAIL rmid_loaded: pend=%b want 110", pend); end
    rstn = 1'b0;
    #1;
    checks++;
    if (pend !== 3'b000 || rdwen !== 1'b0 || rdy !== 3'b111)
      begin errors++; $display("FAIL rmid_async: pend=%b wen=%b rdy=%b want 000/0/111", pend, rdwen, rdy); end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (rdwen !== 1'b0 || pend !== 3'b000)
        begin errors++; $display("FAIL rmid_stale[%0d]: wen=%b pend=%b want 0/000", c, rdwen, pend); end
    end
    $display("reset_mid: buffers discarded, pend=%b", pend);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_full[s] = 1'b0; m_idx[s] = 5'd0; m_dat[s] = 32'd0; m_acc[s] = 1'b0;
      stall[s] = 0; seq[s] = 0;
      sbq[s].delete();
    end
    m_last = 2;
    e_wen = 1'b0; e_idx = 5'd0; e_dat = 32'd0;
  endtask

  // Decide what the next edge does from the current inputs, checking rdy on the way.
  task automatic model_step();
    int g;
    logic [2:0] erdy;
    g = -1;
    for (int k = 1; k <= 3; k++)
      if (g < 0 && m_full[(m_last + k) % 3]) g = (m_last + k) % 3;
    for (int s = 0; s < 3; s++) erdy[s] = !m_full[s] || (g == s);
    checks++;
    if (rdy !== erdy) begin errors++; $display("FAIL rand_rdy: rdy=%b want %b", rdy, erdy); end
    for (int s = 0; s < 3; s++) begin
      stall[s] = (pend[s] && !rdy[s]) ? stall[s] + 1 : 0;
      checks++;
      if (stall[s] > 2) begin errors++; $display("FAIL rand_starve[%0d]: waited %0d cycles, limit 3", s, stall[s] + 1); end
    end
    if (g >= 0) begin
      e_wen = (m_idx[g] != 5'd0); e_idx = m_idx[g]; e_dat = m_dat[g]; m_last = g;
    end else begin
      e_wen = 1'b0;
    end
    for (int s = 0; s < 3; s++) begin
      m_acc[s] = vld[s] && erdy[s];
      if (m_acc[s]) begin
        m_full[s] = 1'b1; m_idx[s] = ridx[s]; m_dat[s] = wdat[s];
        if (ridx[s] != 5'd0) sbq[s].push_back({ridx[s], wdat[s]});
      end else if (g == s) begin
        m_full[s] = 1'b0;
      end
    end
  endtask

  task automatic rand_cycle(input bit allow_new);
    int src;
    logic [36:0] head;
    for (int s = 0; s < 3; s++) begin
      if (!(vld[s] && !m_acc[s])) begin
        vld[s] = allow_new && ($urandom_range(0, 9) < 6);
        ridx[s] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wdat[s] = {2'(s), 30'(seq[s])};
        if (vld[s]) seq[s]++;
      end
    end
    model_step();
    tick();
    checks++;
    if (rdwen !== e_wen || rdidx !== e_idx || rd_wdata !== e_dat || pend !== {m_full[2], m_full[1], m_full[0]})
      begin errors++; $display("FAIL rand_out: wen=%b idx=%0d data=%h pend=%b, want %b %0d %h %b", rdwen, rdidx, rd_wdata, pend, e_wen, e_idx, e_dat, {m_full[2], m_full[1], m_full[0]}); end
    if (rdwen === 1'b1) begin
      src = int'(rd_wdata[31:30]);
      checks++;
      if (src > 2 || sbq[src % 3].size() == 0) begin
        errors++; $display("FAIL rand_sb_unexpected: idx=%0d data=%h has no pending entry", rdidx, rd_wdata);
      end else begin
        head = sbq[src].pop_front();
        if ({rdidx, rd_wdata} !== head)
          begin errors++; $display("FAIL rand_sb_order: got idx=%0d data=%h, want idx=%0d data=%h", rdidx, rd_wdata, head[36:32], head[31:0]); end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    tick();
    for (int c = 0; c < 10000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 8; c++) rand_cycle(1'b0);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (sbq[s].size() != 0) begin errors++; $display("FAIL rand_sb_left[%0d]: %0d writes never appeared, want 0", s, sbq[s].size()); end
    end
    $display("random: accepted alu=%0d lsu=%0d mdu=%0d", seq[0], seq[1], seq[2]);
  endtask

  initial begin
    clear_req();
    test_reset();
    test_single_alu();
    test_all_three();
    test_stream();
    test_x0();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
